present_perm_engine: RTL and testbench

- Parametrised, iterative PRESENT-style bit-permutation engine.
- Applies the generalised forward or inverse pLayer to a DW-bit word a programmable number of times, one application per clock.
- Uses valid/ready handshakes on input and output.
- Sits between the S-box layer and the round-key XOR in the PRESENT datapath. It replaces fixed 64-bit inverse-only wiring, and lets software or the round controller run forward, inverse and multi-round diffusion on one instance.

---
 rtl/present_perm_engine.sv | 122 ++++++++++++
 tb/tb_present_perm_engine.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/present_perm_engine.sv
`default_nettype none
// ============================================================================
// Module      : present_perm_engine
// Description : Iterative PRESENT-style pLayer engine. Applies the forward or
//               inverse bit permutation to a DW-bit word 'reps' times, one
//               application per clock, behind valid/ready handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module present_perm_engine #(
  parameter int DW = 64,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] idat,
  input  logic          inv,
  input  logic [RW-1:0] reps,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] odat,
  output logic          busy
);

  localparam int            c_m   = DW - 1;
  localparam int            c_q   = DW / 4;
  localparam logic [RW-1:0] c_one = {{(RW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_cnt;
  logic          r_inv;
  logic          w_accept;
  logic [DW-1:0] w_fwd;
  logic [DW-1:0] w_inv;
  logic [DW-1:0] w_perm;

  // Multiplying by DW/4 and by 4 modulo DW-1 are mutual inverses, so both
  // maps are bijections and every output bit below is driven exactly once.
  for (genvar gi = 0; gi < c_m; gi++) begin : g_perm
    localparam int c_fwd_pos = (gi * c_q) % c_m;
    localparam int c_inv_pos = (gi * 4) % c_m;
    assign w_fwd[c_fwd_pos] = r_data[gi];
    assign w_inv[c_inv_pos] = r_data[gi];
  end

  assign w_fwd[c_m] = r_data[c_m];
  assign w_inv[c_m] = r_data[c_m];
  assign w_perm     = r_inv ? w_inv : w_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (reps == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt == c_one) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // Releasing the result frees the engine in the same cycle.
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = (reps == '0) ? S_DONE : S_RUN;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
      r_inv  <= 1'b0;
    end else if (w_accept) begin
      r_data <= idat;
      r_cnt  <= reps;
      r_inv  <= inv;
    end else if (r_state == S_RUN) begin
      r_data <= w_perm;
      r_cnt  <= r_cnt - c_one;
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_RUN);
  assign odat      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_present_perm_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_present_perm_engine
// Description : Directed self-checking bench for present_perm_engine
//               (DW=64 main instance, DW=16 parametrisation instance).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_present_perm_engine;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, inv, out_valid, out_ready, busy;
  logic [63:0] idat, odat;
  logic [3:0]  reps;

  logic        in_valid16, in_ready16, inv16, out_valid16, out_ready16, busy16;
  logic [15:0] idat16, odat16;
  logic [3:0]  reps16;

  int tests = 0;
  int fails = 0;

  present_perm_engine #(.DW(64), .RW(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .idat(idat),
    .inv(inv), .reps(reps),
    .out_valid(out_valid), .out_ready(out_ready), .odat(odat),
    .busy(busy)
  );

  present_perm_engine #(.DW(16), .RW(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .idat(idat16),
    .inv(inv16), .reps(reps16),
    .out_valid(out_valid16), .out_ready(out_ready16), .odat(odat16),
    .busy(busy16)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic i, input logic [3:0] r);
    in_valid = 1'b1;
    idat     = d;
    inv      = i;
    reps     = r;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || odat !== 64'h0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b odat=%h, want 1 0 0 0",
               in_ready, out_valid, busy, odat);
    end
    step();
    step();
    rst_n = 1'b1;
    step();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_fwd;
    out_ready = 1'b0;
    send(64'h2, 1'b0, 4'd1);
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL fwd_run: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h1_0000) begin
      fails++;
      $display("FAIL fwd_bit1: out_valid=%b odat=%h, want 1 %h", out_valid, odat, 64'h1_0000);
    end
    drain();
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL fwd_return_idle: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
    send(64'h8000_0000_0000_0001, 1'b0, 4'd1);
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h8000_0000_0000_0001) begin
      fails++;
      $display("FAIL fwd_fixed_bits: out_valid=%b odat=%h, want 1 %h",
               out_valid, odat, 64'h8000_0000_0000_0001);
    end
    drain();
  endtask

  task automatic test_inv;
    send(64'h2, 1'b1, 4'd1);
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h10) begin
      fails++;
      $display("FAIL inv_bit1: out_valid=%b odat=%h, want 1 %h", out_valid, odat, 64'h10);
    end
    drain();
    send(64'h8000, 1'b1, 4'd1);
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h1000_0000_0000_0000) begin
      fails++;
      $display("FAIL inv_bit15: out_valid=%b odat=%h, want 1 %h",
               out_valid, odat, 64'h1000_0000_0000_0000);
    end
    drain();
  endtask

  task automatic test_order3;
    int n_busy = 0;
    int guard  = 0;
    send(64'hDEAD_BEEF_0123_4567, 1'b0, 4'd3);
    while (out_valid !== 1'b1 && guard < 40) begin
      if (busy === 1'b1) n_busy++;
      step();
      guard++;
    end
    tests++;
    if (out_valid !== 1'b1) begin
      fails++;
      $display("FAIL order3_timeout: out_valid=%b after %0d cycles, want 1", out_valid, guard);
    end
    tests++;
    if (n_busy != 3) begin
      fails++;
      $display("FAIL order3_busy_cycles: got %0d, want 3", n_busy);
    end
    tests++;
    if (odat !== 64'hDEAD_BEEF_0123_4567 || busy !== 1'b0) begin
      fails++;
      $display("FAIL order3_identity: odat=%h busy=%b, want %h 0",
               odat, busy, 64'hDEAD_BEEF_0123_4567);
    end
    drain();
  endtask

  task automatic test_reps0_hold;
    out_ready = 1'b0;
    send(64'hA5A5_5A5A_F00F_0FF0, 1'b1, 4'd0);
    tests++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || odat !== 64'hA5A5_5A5A_F00F_0FF0) begin
      fails++;
      $display("FAIL reps0_passthrough: out_valid=%b busy=%b odat=%h, want 1 0 %h",
               out_valid, busy, odat, 64'hA5A5_5A5A_F00F_0FF0);
    end
    // A competing word must stay blocked while the result is unclaimed.
    in_valid = 1'b1;
    idat     = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if (odat !== 64'hA5A5_5A5A_F00F_0FF0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL reps0_hold_c%0d: odat=%h in_ready=%b out_valid=%b, want %h 0 1",
                 c, odat, in_ready, out_valid, 64'hA5A5_5A5A_F00F_0FF0);
      end
    end
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    send(64'h2, 1'b0, 4'd1);
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h1_0000) begin
      fails++;
      $display("FAIL b2b_first: out_valid=%b odat=%h, want 1 %h", out_valid, odat, 64'h1_0000);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    idat      = 64'h8000;
    inv       = 1'b1;
    reps      = 4'd2;
    #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_in_ready: got %b, want 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inv       = 1'b0;
    reps      = 4'd7;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_no_bubble: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    step();
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_second_round: busy=%b out_valid=%b, want 1 0", busy, out_valid);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || odat !== 64'h0008_0000_0000_0000) begin
      fails++;
      $display("FAIL b2b_inv_twice: out_valid=%b odat=%h, want 1 %h",
               out_valid, odat, 64'h0008_0000_0000_0000);
    end
    drain();
  endtask

  task automatic test_reset_mid_run;
    int seen = 0;
    out_ready = 1'b1;
    send(64'hFFFF_0000_1234_5678, 1'b0, 4'd15);
    step();
    step();
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL midrun_busy: got %b, want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || odat !== 64'h0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrun_async_reset: out_valid=%b busy=%b odat=%h in_ready=%b, want 0 0 0 1",
               out_valid, busy, odat, in_ready);
    end
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (out_valid === 1'b1 || busy === 1'b1) seen++;
      step();
    end
    tests++;
    if (seen != 0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrun_no_stale: active cycles=%0d in_ready=%b, want 0 1", seen, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_dw16;
    out_ready16 = 1'b0;
    in_valid16  = 1'b1;
    idat16      = 16'h0002;
    inv16       = 1'b0;
    reps16      = 4'd1;
    step();
    in_valid16  = 1'b0;
    step();
    tests++;
    if (out_valid16 !== 1'b1 || odat16 !== 16'h0010) begin
      fails++;
      $display("FAIL dw16_fwd_bit1: out_valid=%b odat=%h, want 1 0010", out_valid16, odat16);
    end
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
    in_valid16  = 1'b1;
    idat16      = 16'h8101;
    inv16       = 1'b1;
    step();
    in_valid16  = 1'b0;
    step();
    tests++;
    if (out_valid16 !== 1'b1 || odat16 !== 16'h8005) begin
      fails++;
      $display("FAIL dw16_inv_mixed: out_valid=%b odat=%h, want 1 8005", out_valid16, odat16);
    end
    out_ready16 = 1'b1;
    step();
    out_ready16 = 1'b0;
  endtask

  initial begin
    in_valid    = 1'b0;
    idat        = '0;
    inv         = 1'b0;
    reps        = '0;
    out_ready   = 1'b0;
    in_valid16  = 1'b0;
    idat16      = '0;
    inv16       = 1'b0;
    reps16      = '0;
    out_ready16 = 1'b0;

    test_reset();
    test_fwd();
    test_inv();
    test_order3();
    test_reps0_hold();
    test_back_to_back();
    test_reset_mid_run();
    test_dw16();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
